// File: rtl/cdb_arbiter_if.sv
// Bundles the ALU/LSB writeback inputs, the issue-throttle full flags and the CDB broadcast.
// With CDB_BRANCH_EN defined, it also carries the ALU jump/target fields and their CDB copies.
interface cdb_arbiter_if #(
  parameter int ROB_W = 6,
  parameter int XLEN  = 32
);
  logic             alu_valid;
  logic [XLEN-1:0]  alu_res;
  logic [ROB_W-1:0] alu_rob_index;
  logic             alu_full;
  logic             lsb_valid;
  logic [XLEN-1:0]  lsb_res;
  logic [ROB_W-1:0] lsb_rob_index;
  logic             lsb_full;
  logic             cdb_valid;
  logic [XLEN-1:0]  cdb_res;
  logic [ROB_W-1:0] cdb_rob_index;
  logic             cdb_src;
`ifdef CDB_BRANCH_EN
  logic             alu_jump;
  logic [XLEN-1:0]  alu_target_pc;
  logic             cdb_jump;
  logic [XLEN-1:0]  cdb_target_pc;
`endif

  // The arbiter side.
  modport slave (
`ifdef CDB_BRANCH_EN
    input  alu_jump, alu_target_pc,
    output cdb_jump, cdb_target_pc,
`endif
    input  alu_valid, alu_res, alu_rob_index,
    input  lsb_valid, lsb_res, lsb_rob_index,
    output alu_full, lsb_full,
    output cdb_valid, cdb_res, cdb_rob_index, cdb_src
  );

  // The producer/consumer side.
  modport master (
`ifdef CDB_BRANCH_EN
    output alu_jump, alu_target_pc,
    input  cdb_jump, cdb_target_pc,
`endif
    output alu_valid, alu_res, alu_rob_index,
    output lsb_valid, lsb_res, lsb_rob_index,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_res, cdb_rob_index, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one FIFO per source (ALU, LSB) and a round-robin grant of one broadcast per cycle.
// Define CDB_BRANCH_EN to carry the ALU jump/target fields through the ALU FIFO onto the CDB.
module cdb_arbiter #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 6,
  parameter int XLEN  = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          flush,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef CDB_BRANCH_EN
  localparam int AW = XLEN + ROB_W + 1 + XLEN;
`else
  localparam int AW = XLEN + ROB_W;
`endif
  localparam int LW = XLEN + ROB_W;

  logic [AW-1:0]    alu_mem_q [DEPTH];
  logic [AW-1:0]    alu_mem_d [DEPTH];
  logic [LW-1:0]    lsb_mem_q [DEPTH];
  logic [LW-1:0]    lsb_mem_d [DEPTH];
  logic [PW-1:0]    alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
  logic [PW-1:0]    lsb_head_q, lsb_head_d, lsb_tail_q, lsb_tail_d;
  logic [CW-1:0]    alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  logic             prio_q, prio_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [XLEN-1:0]  cdb_res_q, cdb_res_d;
  logic [ROB_W-1:0] cdb_rob_q, cdb_rob_d;
  logic             cdb_src_q, cdb_src_d;
  logic             cdb_jump_q, cdb_jump_d;
  logic [XLEN-1:0]  cdb_target_q, cdb_target_d;

  logic            alu_ne, lsb_ne, grant_alu, grant_lsb, alu_push, lsb_push;
  logic [AW-1:0]   alu_in, alu_head_e;
  logic [LW-1:0]   lsb_head_e;

`ifdef CDB_BRANCH_EN
  assign alu_in = {bus.alu_jump, bus.alu_target_pc, bus.alu_rob_index, bus.alu_res};
`else
  assign alu_in = {bus.alu_rob_index, bus.alu_res};
`endif

  // prio_q set means the LSB wins when both FIFOs hold entries.
  assign alu_ne     = alu_cnt_q != '0;
  assign lsb_ne     = lsb_cnt_q != '0;
  assign grant_lsb  = lsb_ne && (!alu_ne || prio_q);
  assign grant_alu  = alu_ne && !grant_lsb;
  assign alu_push   = bus.alu_valid && (alu_cnt_q != CW'(DEPTH));
  assign lsb_push   = bus.lsb_valid && (lsb_cnt_q != CW'(DEPTH));
  assign alu_head_e = alu_mem_q[alu_head_q];
  assign lsb_head_e = lsb_mem_q[lsb_head_q];

  always_comb begin
    alu_mem_d    = alu_mem_q;
    lsb_mem_d    = lsb_mem_q;
    alu_head_d   = alu_head_q;
    alu_tail_d   = alu_tail_q;
    alu_cnt_d    = alu_cnt_q;
    lsb_head_d   = lsb_head_q;
    lsb_tail_d   = lsb_tail_q;
    lsb_cnt_d    = lsb_cnt_q;
    prio_d       = prio_q;
    cdb_valid_d  = 1'b0;
    cdb_res_d    = cdb_res_q;
    cdb_rob_d    = cdb_rob_q;
    cdb_src_d    = cdb_src_q;
    cdb_jump_d   = cdb_jump_q;
    cdb_target_d = cdb_target_q;
    if (flush) begin
      alu_head_d = '0;
      alu_tail_d = '0;
      alu_cnt_d  = '0;
      lsb_head_d = '0;
      lsb_tail_d = '0;
      lsb_cnt_d  = '0;
      prio_d     = 1'b0;
    end else begin
      if (alu_push) begin
        alu_mem_d[alu_tail_q] = alu_in;
        alu_tail_d            = alu_tail_q + PW'(1);
      end
      if (lsb_push) begin
        lsb_mem_d[lsb_tail_q] = {bus.lsb_rob_index, bus.lsb_res};
        lsb_tail_d            = lsb_tail_q + PW'(1);
      end
      if (grant_alu) begin
        cdb_valid_d = 1'b1;
        cdb_res_d   = alu_head_e[XLEN-1:0];
        cdb_rob_d   = alu_head_e[XLEN +: ROB_W];
        cdb_src_d   = 1'b0;
`ifdef CDB_BRANCH_EN
        cdb_target_d = alu_head_e[XLEN+ROB_W +: XLEN];
        cdb_jump_d   = alu_head_e[AW-1];
`endif
        alu_head_d  = alu_head_q + PW'(1);
        prio_d      = 1'b1;
      end
      if (grant_lsb) begin
        cdb_valid_d  = 1'b1;
        cdb_res_d    = lsb_head_e[XLEN-1:0];
        cdb_rob_d    = lsb_head_e[XLEN +: ROB_W];
        cdb_src_d    = 1'b1;
        cdb_jump_d   = 1'b0;
        cdb_target_d = '0;
        lsb_head_d   = lsb_head_q + PW'(1);
        prio_d       = 1'b0;
      end
      alu_cnt_d = alu_cnt_q + CW'(alu_push) - CW'(grant_alu);
      lsb_cnt_d = lsb_cnt_q + CW'(lsb_push) - CW'(grant_lsb);
    end
  end

  // FIFO storage is not reset; only the pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_head_q   <= '0;
      alu_tail_q   <= '0;
      alu_cnt_q    <= '0;
      lsb_head_q   <= '0;
      lsb_tail_q   <= '0;
      lsb_cnt_q    <= '0;
      prio_q       <= 1'b0;
      cdb_valid_q  <= 1'b0;
      cdb_res_q    <= '0;
      cdb_rob_q    <= '0;
      cdb_src_q    <= 1'b0;
      cdb_jump_q   <= 1'b0;
      cdb_target_q <= '0;
    end else if (rdy) begin
      if (!flush) begin
        alu_overflow: assert (!(bus.alu_valid && alu_cnt_q == CW'(DEPTH)))
          else $error("cdb_arbiter: ALU push dropped, FIFO already holds DEPTH entries");
        lsb_overflow: assert (!(bus.lsb_valid && lsb_cnt_q == CW'(DEPTH)))
          else $error("cdb_arbiter: LSB push dropped, FIFO already holds DEPTH entries");
      end
      alu_mem_q    <= alu_mem_d;
      lsb_mem_q    <= lsb_mem_d;
      alu_head_q   <= alu_head_d;
      alu_tail_q   <= alu_tail_d;
      alu_cnt_q    <= alu_cnt_d;
      lsb_head_q   <= lsb_head_d;
      lsb_tail_q   <= lsb_tail_d;
      lsb_cnt_q    <= lsb_cnt_d;
      prio_q       <= prio_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_res_q    <= cdb_res_d;
      cdb_rob_q    <= cdb_rob_d;
      cdb_src_q    <= cdb_src_d;
      cdb_jump_q   <= cdb_jump_d;
      cdb_target_q <= cdb_target_d;
    end
  end

  // One slack entry absorbs a result already in flight when full rises.
  assign bus.alu_full      = alu_cnt_q >= CW'(DEPTH - 1);
  assign bus.lsb_full      = lsb_cnt_q >= CW'(DEPTH - 1);
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_res       = cdb_res_q;
  assign bus.cdb_rob_index = cdb_rob_q;
  assign bus.cdb_src       = cdb_src_q;
`ifdef CDB_BRANCH_EN
  assign bus.cdb_jump      = cdb_jump_q;
  assign bus.cdb_target_pc = cdb_target_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios then random traffic, all checked against a
// queue-based model of the two FIFOs and the alternating grant.
module tb_cdb_arbiter;
  localparam int DEPTH = 4;
  localparam int ROB_W = 6;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic rst, rdy, flush;

  cdb_arbiter_if #(.ROB_W(ROB_W), .XLEN(XLEN)) bus ();

  cdb_arbiter #(.DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [ROB_W-1:0] rob;
    logic             jump;
    logic [XLEN-1:0]  tgt;
  } ent_t;

  ent_t alu_q[$];
  ent_t lsb_q[$];
  logic             m_valid, m_src, m_jump;
  logic [XLEN-1:0]  m_res, m_tgt;
  logic [ROB_W-1:0] m_rob;
  logic             last_was_alu;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour at one clock edge, from the inputs present at that edge.
  task automatic modelEdge();
    ent_t e;
    bool_pick: begin end
    if (rst) begin
      alu_q.delete();
      lsb_q.delete();
      m_valid = 0; m_src = 0; m_jump = 0; m_res = '0; m_tgt = '0; m_rob = '0;
      last_was_alu = 0;
    end else if (rdy) begin
      if (flush) begin
        alu_q.delete();
        lsb_q.delete();
        m_valid = 0;
        last_was_alu = 0;
      end else begin
        int na = alu_q.size();
        int nl = lsb_q.size();
        bit take_lsb;
        if (na > 0 && nl > 0) take_lsb = last_was_alu;
        else take_lsb = (nl > 0);
        m_valid = (na + nl) > 0;
        if (m_valid) begin
          if (take_lsb) begin
            e = lsb_q.pop_front();
            e.jump = 0;
            e.tgt = '0;
          end else begin
            e = alu_q.pop_front();
          end
          m_res = e.res; m_rob = e.rob; m_jump = e.jump; m_tgt = e.tgt;
          m_src = take_lsb;
          last_was_alu = !take_lsb;
        end
        if (bus.alu_valid && na < DEPTH) begin
          e.res = bus.alu_res; e.rob = bus.alu_rob_index;
`ifdef CDB_BRANCH_EN
          e.jump = bus.alu_jump; e.tgt = bus.alu_target_pc;
`else
          e.jump = 0; e.tgt = '0;
`endif
          alu_q.push_back(e);
        end
        if (bus.lsb_valid && nl < DEPTH) begin
          e.res = bus.lsb_res; e.rob = bus.lsb_rob_index; e.jump = 0; e.tgt = '0;
          lsb_q.push_back(e);
        end
      end
    end
  endtask

  task automatic checkOutput();
    check("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    check("cdb_res", 64'(bus.cdb_res), 64'(m_res));
    check("cdb_rob_index", 64'(bus.cdb_rob_index), 64'(m_rob));
    check("cdb_src", 64'(bus.cdb_src), 64'(m_src));
    check("alu_full", 64'(bus.alu_full), 64'(alu_q.size() >= DEPTH - 1));
    check("lsb_full", 64'(bus.lsb_full), 64'(lsb_q.size() >= DEPTH - 1));
`ifdef CDB_BRANCH_EN
    check("cdb_jump", 64'(bus.cdb_jump), 64'(m_jump));
    check("cdb_target_pc", 64'(bus.cdb_target_pc), 64'(m_tgt));
`endif
  endtask

  task automatic applyStimulus(input bit av, input logic [XLEN-1:0] ares, input logic [ROB_W-1:0] arob,
                               input bit lv, input logic [XLEN-1:0] lres, input logic [ROB_W-1:0] lrob,
                               input bit fl = 0, input bit rd = 1, input bit rs = 0,
                               input bit jmp = 0, input logic [XLEN-1:0] tgt = '0);
    bus.alu_valid = av; bus.alu_res = ares; bus.alu_rob_index = arob;
    bus.lsb_valid = lv; bus.lsb_res = lres; bus.lsb_rob_index = lrob;
`ifdef CDB_BRANCH_EN
    bus.alu_jump = jmp; bus.alu_target_pc = tgt;
`endif
    flush = fl; rdy = rd; rst = rs;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_res = '0; bus.alu_rob_index = '0;
    bus.lsb_valid = 0; bus.lsb_res = '0; bus.lsb_rob_index = '0;
`ifdef CDB_BRANCH_EN
    bus.alu_jump = 0; bus.alu_target_pc = '0;
`endif
    rst = 1; rdy = 1; flush = 0;
    #1;
    applyStimulus(0, '0, '0, 0, '0, '0, 0, 1, 1);
    applyStimulus(0, '0, '0, 0, '0, '0, 0, 1, 1);
    check("reset_valid", 64'(bus.cdb_valid), 64'd0);
    check("reset_res", 64'(bus.cdb_res), 64'd0);

    // Single ALU result appears two cycles after it is offered.
    applyStimulus(1, 32'h11, 6'd3, 0, '0, '0);
    check("lat_not_early", 64'(bus.cdb_valid), 64'd0);
    idle(1);
    check("lat_valid", 64'(bus.cdb_valid), 64'd1);
    check("lat_res", 64'(bus.cdb_res), 64'h11);
    check("lat_rob", 64'(bus.cdb_rob_index), 64'd3);
    check("lat_src", 64'(bus.cdb_src), 64'd0);
    idle(1);
    check("lat_drop", 64'(bus.cdb_valid), 64'd0);

    // Simultaneous results from a freshly reset state: ALU first.
    applyStimulus(0, '0, '0, 0, '0, '0, 0, 1, 1);
    applyStimulus(1, 32'hA, 6'd1, 1, 32'hB, 6'd2);
    idle(1);
    check("pair_first", 64'(bus.cdb_res), 64'hA);
    idle(1);
    check("pair_second", 64'(bus.cdb_res), 64'hB);
    check("pair_second_src", 64'(bus.cdb_src), 64'd1);
    // A lone ALU grant leaves the LSB preferred for the next contended pair.
    applyStimulus(1, 32'hC, 6'd4, 0, '0, '0);
    applyStimulus(1, 32'hA, 6'd1, 1, 32'hB, 6'd2);
    check("alt_lone", 64'(bus.cdb_res), 64'hC);
    idle(1);
    check("alt_lsb_first", 64'(bus.cdb_src), 64'd1);
    idle(1);
    check("alt_alu_next", 64'(bus.cdb_src), 64'd0);
    idle(2);

    // Both sources pushing every cycle build up backlog and raise the full flags.
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 32'h100 + i, 6'(i), 1, 32'h200 + i, 6'(i + 8));
    check("stream_lsb_full", 64'(bus.lsb_full), 64'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, '0, '0, 0, '0, '0);
      if (i < 7) check("stream_no_gap", 64'(bus.cdb_valid), 64'd1);
    end
    idle(2);

    // Flush discards buffered entries and the flush-cycle input.
    for (int i = 0; i < 2; i++) applyStimulus(1, 32'h300 + i, 6'(20 + i), 1, 32'h400 + i, 6'(30 + i), 0, 0);
    applyStimulus(1, 32'h301, 6'd21, 1, 32'h401, 6'd31);
    applyStimulus(1, 32'hDEAD, 6'h3F, 0, '0, '0, 1);
    check("flush_valid", 64'(bus.cdb_valid), 64'd0);
    check("flush_alu_full", 64'(bus.alu_full), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("flush_quiet", 64'(bus.cdb_valid), 64'd0);
    end

    // rdy low mid-stream freezes everything.
    applyStimulus(1, 32'h500, 6'd5, 1, 32'h600, 6'd6);
    applyStimulus(1, 32'h501, 6'd7, 1, 32'h601, 6'd8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'hBAD, 6'd9, 1, 32'hBAD, 6'd9, 0, 0);
      check("freeze_res", 64'(bus.cdb_res), 64'h500);
    end
    idle(5);

`ifdef CDB_BRANCH_EN
    applyStimulus(1, 32'h7, 6'd10, 0, '0, '0, 0, 1, 0, 1, 32'h1000);
    applyStimulus(0, '0, '0, 1, 32'h8, 6'd11);
    check("br_jump", 64'(bus.cdb_jump), 64'd1);
    check("br_target", 64'(bus.cdb_target_pc), 64'h1000);
    idle(1);
    check("br_lsb_jump", 64'(bus.cdb_jump), 64'd0);
    check("br_lsb_target", 64'(bus.cdb_target_pc), 64'd0);
    idle(2);
`endif

    // Random traffic; producers never push into a FIFO that already holds DEPTH entries.
    for (int i = 0; i < 400; i++) begin
      bit av, lv, fl, rd, rs;
      av = ($urandom_range(0, 9) < 6) && (alu_q.size() < DEPTH);
      lv = ($urandom_range(0, 9) < 5) && (lsb_q.size() < DEPTH);
      fl = ($urandom_range(0, 49) == 0);
      rd = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 99) == 0);
      applyStimulus(av, $urandom, 6'($urandom), lv, $urandom, 6'($urandom), fl, rd, rs,
                    1'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
